// File: rtl/rv32i_types.sv
// Shared RV32 types: M-extension funct3 encodings and the
// state/iteration constants of the multi-cycle mul/div sequencer.
package rv32i_types;

    typedef enum logic [2:0] {
        F3_MUL    = 3'd0,
        F3_MULH   = 3'd1,
        F3_MULHSU = 3'd2,
        F3_MULHU  = 3'd3,
        F3_DIV    = 3'd4,
        F3_DIVU   = 3'd5,
        F3_REM    = 3'd6,
        F3_REMU   = 3'd7
    } muldiv_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } muldiv_seq_state_t;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_ITERS = MULDIV_WIDTH;

endpackage

// File: rtl/muldiv_iter.sv
// Unsigned radix-2 datapath: shift-add multiply and restoring divide
// sharing one 2*WIDTH accumulator ({remainder, quotient} when dividing).
module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               step,
    input  logic               is_div,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] prod,
    output logic [WIDTH-1:0]   quot,
    output logic [WIDTH-1:0]   rem
);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   m;
    logic               div_q;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;

    // Outputs show the value after the current step so the final
    // iteration can be registered straight into the response.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
        diff    = acc[2*WIDTH-1:WIDTH-1] - {1'b0, m};
        acc_nxt = acc;
        if (step) begin
            if (div_q) begin
                if (!diff[WIDTH]) begin
                    acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                end else begin
                    acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_nxt = {sum, acc[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            m     <= '0;
            div_q <= 1'b0;
        end else if (init) begin
            acc   <= {{WIDTH{1'b0}}, (is_div ? a : b)};
            m     <= is_div ? b : a;
            div_q <= is_div;
        end else begin
            acc   <= acc_nxt;
        end
    end

    assign prod = acc_nxt;
    assign quot = acc_nxt[WIDTH-1:0];
    assign rem  = acc_nxt[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multi-cycle sequencer: FSM, iteration counter, operand sign
// handling and special cases around the unsigned muldiv_iter datapath.
module muldiv_sequencer
    import rv32i_types::*;
#(
    parameter int WIDTH = MULDIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data,
    input  logic             resp_ack,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    muldiv_seq_state_t state;
    muldiv_funct3_t    op_q;
    muldiv_funct3_t    op_in;
    logic [CW-1:0]     cnt;
    logic              neg_q;

    logic              sgn1, sgn2, s1, s2;
    logic              is_div_in, is_rem_in;
    logic              by_zero, ovf, special, neg_in;
    logic [WIDTH-1:0]  abs1, abs2, spec_val;
    logic              init, step;

    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quot, rem, quot_fix, rem_fix;
    logic [WIDTH-1:0]   result;

    always_comb begin
        op_in     = muldiv_funct3_t'(funct3);
        sgn1      = (op_in == F3_MULH) || (op_in == F3_MULHSU) ||
                    (op_in == F3_DIV)  || (op_in == F3_REM);
        sgn2      = (op_in == F3_MULH) || (op_in == F3_DIV) ||
                    (op_in == F3_REM);
        s1        = sgn1 && rs1[WIDTH-1];
        s2        = sgn2 && rs2[WIDTH-1];
        abs1      = s1 ? -rs1 : rs1;
        abs2      = s2 ? -rs2 : rs2;
        is_div_in = funct3[2];
        is_rem_in = funct3[2] && funct3[1];
        neg_in    = is_rem_in ? s1 : (s1 ^ s2);
        by_zero   = is_div_in && (rs2 == '0);
        ovf       = ((op_in == F3_DIV) || (op_in == F3_REM)) &&
                    (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (rs2 == '1);
        special   = by_zero || ovf;
        spec_val  = '0;
        if (by_zero) begin
            spec_val = is_rem_in ? rs1 : '1;
        end else if (!is_rem_in) begin
            spec_val = rs1;
        end
    end

    assign init = !rst && !flush && (state == IDLE) && req_valid && !special;
    assign step = !rst && !flush && (state == BUSY);

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .init   (init),
        .step   (step),
        .is_div (is_div_in),
        .a      (abs1),
        .b      (abs2),
        .prod   (prod),
        .quot   (quot),
        .rem    (rem)
    );

    // Negation happens on the full product so mulh* high halves are exact.
    always_comb begin
        prod_fix = neg_q ? -prod : prod;
        quot_fix = neg_q ? -quot : quot;
        rem_fix  = neg_q ? -rem : rem;
        result   = '0;
        unique case (op_q)
            F3_MUL:                       result = prod_fix[WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*WIDTH-1:WIDTH];
            F3_DIV, F3_DIVU:              result = quot_fix;
            default:                      result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            op_q       <= F3_MUL;
            neg_q      <= 1'b0;
        end else if (flush) begin
            state      <= IDLE;
            cnt        <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q      <= op_in;
                        neg_q     <= neg_in;
                        req_ready <= 1'b0;
                        cnt       <= '0;
                        if (special) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_data  <= spec_val;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (cnt == LAST) begin
                        state      <= DONE;
                        cnt        <= '0;
                        resp_valid <= 1'b1;
                        resp_data  <= result;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (resp_ack) begin
                        state      <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign stall = req_valid && !(resp_valid && resp_ack);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed RV32M cases, abort
// scenarios and random ops checked against a plain-arithmetic model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_ack;
    logic        stall;

    int chk = 0;
    int err = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    logic valid_prev = 1'b0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .funct3     (funct3),
        .rs1        (rs1),
        .rs2        (rs2),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_ack   (resp_ack),
        .stall      (stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        chk++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic logic is_special(input logic [2:0] f,
                                        input logic [31:0] x,
                                        input logic [31:0] y);
        if (f[2] && y == 32'd0) return 1'b1;
        if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 &&
            y == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        logic [63:0] p;
        longint sx, sy, ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (f)
            3'd0: begin p = 64'(ux * uy); return p[31:0]; end
            3'd1: begin p = 64'(sx * sy); return p[63:32]; end
            3'd2: begin p = 64'(sx * uy); return p[63:32]; end
            3'd3: begin p = 64'(ux * uy); return p[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (is_special(f, x, y)) return x;
                return $signed(x) / $signed(y);
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (is_special(f, x, y)) return 32'd0;
                return $signed(x) % $signed(y);
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    // Monitor: stall equation, first-valid data and latency, hold stability.
    always @(negedge clk) begin
        check("stall", {31'd0, stall},
              {31'd0, req_valid && !(resp_valid && resp_ack)});
        if (resp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", {31'd0, resp_valid}, 32'd0);
            end else begin
                if (!valid_prev) begin
                    check("resp_data", resp_data, exp_q[0].data);
                    check("latency", 32'(cyc - exp_q[0].cyc),
                          32'(exp_q[0].lat));
                end else begin
                    check("hold_data", resp_data, exp_q[0].data);
                end
                if (resp_ack) void'(exp_q.pop_front());
            end
        end
        valid_prev = resp_valid;
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y);
        exp_t e;
        wait_ready();
        req_valid = 1'b1;
        funct3    = f;
        rs1       = x;
        rs2       = y;
        e.data = model(f, x, y);
        e.cyc  = cyc;
        e.lat  = is_special(f, x, y) ? 1 : 33;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rs1    = $urandom;
        rs2    = $urandom;
        funct3 = 3'($urandom);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        int n = 0;
        issue(f, x, y);
        while (!resp_valid && n < 60) begin
            resp_ack = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            n++;
        end
        resp_ack = 1'b0;
        if (!resp_valid) begin
            check("resp_timeout", 32'd0, 32'd1);
            flush = 1'b1;
            @(posedge clk); #1;
            flush = 1'b0;
            req_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        repeat (hold) begin @(posedge clk); #1; end
        check("busy_not_ready", {31'd0, req_ready}, 32'd0);
        resp_ack = 1'b1;
        @(posedge clk); #1;
        resp_ack  = 1'b0;
        req_valid = 1'b0;
        check("ack_valid_low", {31'd0, resp_valid}, 32'd0);
        check("ack_ready", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_abort(input logic [2:0] f, input logic [31:0] x,
                             input logic [31:0] y, input int k,
                             input bit use_rst);
        issue(f, x, y);
        repeat (k) begin @(posedge clk); #1; end
        if (use_rst) rst = 1'b1;
        else flush = 1'b1;
        @(posedge clk); #1;
        rst       = 1'b0;
        flush     = 1'b0;
        req_valid = 1'b0;
        void'(exp_q.pop_back());
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        check("abort_valid", {31'd0, resp_valid}, 32'd0);
        if (use_rst) check("rst_data", resp_data, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        req_valid = 1'b0;
        resp_ack  = 1'b0;
        funct3    = 3'd0;
        rs1       = 32'd0;
        rs2       = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, req_ready}, 32'd1);
        check("reset_valid", {31'd0, resp_valid}, 32'd0);
        check("reset_data", resp_data, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd7, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 10);

        run_abort(3'd0, 32'd5, 32'd6, 12, 1'b0);
        run_op(3'd0, 32'd3, 32'd4, 0);
        run_abort(3'd4, 32'd100, 32'd7, 20, 1'b1);
        run_abort(3'd5, 32'd5, 32'd0, 0, 1'b0);

        // flush together with a request in IDLE must not accept it
        req_valid = 1'b1;
        flush     = 1'b1;
        funct3    = 3'd0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        flush     = 1'b0;
        check("flush_idle_ready", {31'd0, req_ready}, 32'd1);
        repeat (40) begin @(posedge clk); #1; end

        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom), pick(), pick(), $urandom_range(0, 3));
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", chk, err);
        $finish;
    end

endmodule
